// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU codes, control encodings, the ctrl_t bundle
// and the skid-buffer state type.
package decode_pkg;

  localparam int PC_W  = 32;
  localparam int ALU_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALU_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [ALU_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [ALU_W-1:0] ALU_AND  = 5'd2;
  localparam logic [ALU_W-1:0] ALU_OR   = 5'd3;
  localparam logic [ALU_W-1:0] ALU_XOR  = 5'd4;
  localparam logic [ALU_W-1:0] ALU_SLL  = 5'd5;
  localparam logic [ALU_W-1:0] ALU_SRL  = 5'd6;
  localparam logic [ALU_W-1:0] ALU_SRA  = 5'd7;
  localparam logic [ALU_W-1:0] ALU_SLT  = 5'd8;
  localparam logic [ALU_W-1:0] ALU_SLTU = 5'd9;
  localparam logic [ALU_W-1:0] ALU_LUI  = 5'd15;
  localparam logic [ALU_W-1:0] ALU_MUL  = 5'd16;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} st_e;

  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic             alu_src_a;
    logic             alu_src_b;
    logic             branch;
    logic [ALU_W-1:0] alu;
    logic [1:0]       result_src;
    logic [2:0]       branch_type;
    logic [2:0]       addressing;
    logic [1:0]       jump;
    logic [2:0]       imm_src;
    logic             illegal;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [PC_W-1:0]  pc;
    logic [31:0]      instr;
  } ctrl_t;

  // Register-register / shift ALU selection; alt picks sub or sra.
  function automatic logic [ALU_W-1:0] alu_of_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of_f3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of_f3 = ALU_SLL;
      3'b010:  alu_of_f3 = ALU_SLT;
      3'b011:  alu_of_f3 = ALU_SLTU;
      3'b100:  alu_of_f3 = ALU_XOR;
      3'b101:  alu_of_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of_f3 = ALU_OR;
      default: alu_of_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I decoder producing ctrl_t (pc left zero for the caller to fill).
// RV32M_EN adds legal decode of the funct7=0000001 multiply/divide group.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] op, f7;
  logic [2:0] f3;
  logic       ill;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  always_comb begin
    ctrl       = '0;
    ill        = 1'b0;
    ctrl.rd    = instr[11:7];
    ctrl.rs1   = instr[19:15];
    ctrl.rs2   = instr[24:20];
    ctrl.instr = instr;
    case (op)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        if (f7 == 7'b0000001) begin
`ifdef RV32M_EN
          ctrl.alu = ALU_MUL | {2'b00, f3};
`else
          ill = 1'b1;
`endif
        end else begin
          ctrl.alu = alu_of_f3(f3, f7[5]);
          if (!(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
            ill = 1'b1;
        end
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.alu       = alu_of_f3(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001 && f7 != 7'b0) ill = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000) ill = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.imm_src    = IMM_I;
        ctrl.addressing = f3;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.imm_src    = IMM_S;
        ctrl.addressing = f3;
        if (f3 > 3'b010) ill = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch      = 1'b1;
        ctrl.imm_src     = IMM_B;
        ctrl.branch_type = f3;
        case (f3[2:1])
          2'b00:   ctrl.alu = ALU_SUB;
          2'b10:   ctrl.alu = ALU_SLT;
          2'b11:   ctrl.alu = ALU_SLTU;
          default: ill = 1'b1;
        endcase
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = JMP_JAL;
        ctrl.result_src = RES_PC4;
        ctrl.imm_src    = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = JMP_JALR;
        ctrl.result_src = RES_PC4;
        ctrl.alu_src_b  = 1'b1;
        ctrl.imm_src    = IMM_I;
        if (f3 != 3'b000) ill = 1'b1;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.alu       = ALU_LUI;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_src   = IMM_U;
      end
      default: ill = 1'b1;
    endcase
    // Illegal entries must never have architectural side effects downstream.
    if (ill) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jump      = JMP_NONE;
    end
    ctrl.illegal = ill;
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage: decode at the input, 2-entry skid buffer, flush, illegal counter.
// Define RV32M_EN to accept the multiply/divide group (requires ALU_CTRL_W >= 5).
module decode_ctrl_stage
  import decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  reg_write,
  output logic                  mem_write,
  output logic                  alu_src_a,
  output logic                  alu_src_b,
  output logic                  branch,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            result_src,
  output logic [2:0]            branch_type,
  output logic [2:0]            addressing_control,
  output logic [1:0]            jump,
  output logic [2:0]            imm_src,
  output logic [4:0]            rd,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [XLEN-1:0]       out_pc,
  output logic [31:0]           out_instr,
  output logic                  illegal,
  output logic [CNT_W-1:0]      illegal_count
);

`ifdef RV32M_EN
  if (ALU_CTRL_W < 5) begin : g_alu_w_check
    $error("ALU_CTRL_W must be at least 5 when RV32M_EN is defined");
  end
`endif

  st_e        state, state_nx;
  ctrl_t      dec, dec_in, head, skid;
  logic       in_xfer, out_xfer;
  logic       load_head, head_from_skid, load_skid;
  logic [CNT_W-1:0] cnt;

  decode_comb u_dec (.instr(in_instr), .ctrl(dec));

  always_comb begin
    dec_in    = dec;
    dec_in.pc = PC_W'(in_pc);
  end

  assign in_ready  = rst_n && (state != S_TWO);
  assign out_valid = (state != S_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      S_EMPTY: if (in_xfer) begin
        state_nx  = S_ONE;
        load_head = 1'b1;
      end
      S_ONE: begin
        if (in_xfer && out_xfer) load_head = 1'b1;
        else if (in_xfer) begin
          state_nx  = S_TWO;
          load_skid = 1'b1;
        end else if (out_xfer) state_nx = S_EMPTY;
      end
      S_TWO: if (out_xfer) begin
        state_nx       = S_ONE;
        load_head      = 1'b1;
        head_from_skid = 1'b1;
      end
      default: state_nx = S_EMPTY;
    endcase
    // Flush wins over everything; buffer contents become don't-care once EMPTY.
    if (flush_i) begin
      state_nx  = S_EMPTY;
      load_head = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
      cnt  <= '0;
    end else begin
      if (load_head) head <= head_from_skid ? skid : dec_in;
      if (load_skid) skid <= dec_in;
      if (in_xfer && !flush_i && dec.illegal && cnt != {CNT_W{1'b1}})
        cnt <= cnt + 1'b1;
    end
  end

  assign reg_write          = head.reg_write;
  assign mem_write          = head.mem_write;
  assign alu_src_a          = head.alu_src_a;
  assign alu_src_b          = head.alu_src_b;
  assign branch             = head.branch;
  assign alu_control        = ALU_CTRL_W'(head.alu);
  assign result_src         = head.result_src;
  assign branch_type        = head.branch_type;
  assign addressing_control = head.addressing;
  assign jump               = head.jump;
  assign imm_src            = head.imm_src;
  assign rd                 = head.rd;
  assign rs1                = head.rs1;
  assign rs2                = head.rs2;
  assign out_pc             = XLEN'(head.pc);
  assign out_instr          = head.instr;
  assign illegal            = head.illegal;
  assign illegal_count      = cnt;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: reset, decode, backpressure, illegal counting,
// flush and the RV32M_EN-dependent multiply decode.
module tb_decode_ctrl_stage;

`ifdef RV32M_EN
  localparam int ALU_W = 5;
`else
  localparam int ALU_W = 4;
`endif
  localparam int XLEN  = 32;
  localparam int CNT_W = 8;

  localparam logic [31:0] I_SUB  = 32'h40208033;
  localparam logic [31:0] I_LW   = 32'h0000A083;
  localparam logic [31:0] I_ADD  = 32'h00208033;
  localparam logic [31:0] I_XOR  = 32'h0020C1B3;
  localparam logic [31:0] I_LD   = 32'h0000B003;
  localparam logic [31:0] I_MUL  = 32'h02208033;
  localparam logic [31:0] I_JAL  = 32'h000000EF;
  localparam logic [31:0] I_BEQ  = 32'h00208063;

  logic clk, rst_n, flush_i, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, out_instr;
  logic [XLEN-1:0] in_pc, out_pc;
  logic reg_write, mem_write, alu_src_a, alu_src_b, branch, illegal;
  logic [ALU_W-1:0] alu_control;
  logic [1:0] result_src, jump;
  logic [2:0] branch_type, addressing_control, imm_src;
  logic [4:0] rd, rs1, rs2;
  logic [CNT_W-1:0] illegal_count;

  int checks = 0;
  int errors = 0;

  decode_ctrl_stage #(.XLEN(XLEN), .ALU_CTRL_W(ALU_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_write(reg_write), .mem_write(mem_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .branch(branch), .alu_control(alu_control),
    .result_src(result_src), .branch_type(branch_type),
    .addressing_control(addressing_control), .jump(jump), .imm_src(imm_src),
    .rd(rd), .rs1(rs1), .rs2(rs2), .out_pc(out_pc), .out_instr(out_instr),
    .illegal(illegal), .illegal_count(illegal_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_instr = I_SUB; in_pc = 32'h0;

    // Reset held with valid input: nothing accepted
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", illegal_count, 0);
    chk("rst_reg_write", reg_write, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // sub x0,x1,x2
    in_valid = 1'b1; in_instr = I_SUB; in_pc = 32'h100; out_ready = 1'b1;
    tick();
    chk("sub_valid", out_valid, 1);
    chk("sub_alu", alu_control, 1);
    chk("sub_reg_write", reg_write, 1);
    chk("sub_rs1", rs1, 1);
    chk("sub_rs2", rs2, 2);
    chk("sub_pc", out_pc, 32'h100);
    chk("sub_illegal", illegal, 0);

    // lw x1,0(x1) replaces the consumed sub in the same cycle
    in_instr = I_LW; in_pc = 32'h104;
    tick();
    in_valid = 1'b0;
    chk("lw_result_src", result_src, 1);
    chk("lw_alu_src_b", alu_src_b, 1);
    chk("lw_addr", addressing_control, 3'b010);
    chk("lw_rd", rd, 1);
    chk("lw_alu", alu_control, 0);
    chk("lw_instr", out_instr, I_LW);
    tick();
    chk("drain_valid", out_valid, 0);

    // Backpressure: fill both entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h200;
    tick();
    in_instr = I_XOR; in_pc = 32'h204;
    tick();
    in_instr = I_SUB; in_pc = 32'h208;
    chk("two_in_ready", in_ready, 0);
    chk("two_head_pc", out_pc, 32'h200);
    tick();
    chk("stall_head_pc", out_pc, 32'h200);
    chk("stall_head_alu", alu_control, 0);
    chk("stall_valid", out_valid, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("skid_pc", out_pc, 32'h204);
    chk("skid_alu", alu_control, 4);
    chk("skid_rd", rd, 3);
    chk("skid_in_ready", in_ready, 1);
    tick();
    chk("bp_empty", out_valid, 0);

    // Illegal load funct3=011
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = I_LD; in_pc = 32'h300;
    tick();
    in_valid = 1'b0;
    chk("ld_illegal", illegal, 1);
    chk("ld_reg_write", reg_write, 0);
    chk("ld_count", illegal_count, 1);

    // Flush from TWO with an illegal instruction presented
    in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h304;
    tick();
    flush_i = 1'b1; in_instr = I_LD;
    tick();
    flush_i = 1'b0; in_valid = 1'b0;
    chk("flush2_valid", out_valid, 0);
    chk("flush2_in_ready", in_ready, 1);
    chk("flush2_count", illegal_count, 1);

    // Flush from ONE drops an otherwise-accepted illegal instruction
    in_valid = 1'b1; in_instr = I_ADD;
    tick();
    flush_i = 1'b1; in_instr = I_LD;
    tick();
    flush_i = 1'b0; in_valid = 1'b0;
    chk("flush1_valid", out_valid, 0);
    chk("flush1_count", illegal_count, 1);

    // Stream 261 illegal instructions; count saturates at 255
    out_ready = 1'b1; in_valid = 1'b1; in_instr = I_LD;
    repeat (253) tick();
    chk("sat_pre", illegal_count, 254);
    repeat (8) tick();
    chk("sat_count", illegal_count, 255);
    chk("sat_jump", jump, 0);
    chk("sat_mem_write", mem_write, 0);

    // RV32M mul
    in_instr = I_MUL;
    tick();
`ifdef RV32M_EN
    chk("mul_alu", alu_control, 16);
    chk("mul_illegal", illegal, 0);
    chk("mul_reg_write", reg_write, 1);
`else
    chk("mul_illegal", illegal, 1);
    chk("mul_reg_write", reg_write, 0);
`endif

    // JAL and BEQ
    in_instr = I_JAL;
    tick();
    chk("jal_jump", jump, 1);
    chk("jal_result_src", result_src, 2);
    chk("jal_imm_src", imm_src, 3);
    in_instr = I_BEQ;
    tick();
    in_valid = 1'b0;
    chk("beq_branch", branch, 1);
    chk("beq_alu", alu_control, 1);
    chk("beq_imm_src", imm_src, 2);
    chk("beq_reg_write", reg_write, 0);
    tick();
    chk("end_empty", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
- Registered successor to the combinational instruction decoder.
- Sits between IF and EX. Accepts instructions over a valid/ready handshake, decodes them to the full control bundle plus register indices, and holds the result in a 2-entry skid buffer.
- Adds illegal-instruction detection with a saturating counter, flush, and an ALU control width that is wide enough for optional RV32M decode.

Parameters:
- XLEN, 32, width of the PC field.
- ALU_CTRL_W, 4, width of alu_control. Must be at least 5 when RV32M_EN is defined; elaboration error otherwise.
- CNT_W, 8, width of illegal_count.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- flush_i  in  1  discard all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head entry
- reg_write, mem_write, alu_src_a, alu_src_b, branch  out  1 each  control bits, same meaning as the existing decoder
- alu_control  out  ALU_CTRL_W  ALU operation
- result_src  out  2  00 ALU, 01 memory, 10 PC+4
- branch_type, addressing_control  out  3 each  funct3 pass-through
- jump  out  2  00 none, 01 JAL, 10 JALR
- imm_src  out  3  I 000, S 001, B 010, J 011, U 100
- rd, rs1, rs2  out  5 each  register indices
- out_pc  out  XLEN;  out_instr  out  32  pass-through
- illegal  out  1  head entry is an illegal instruction
- illegal_count  out  CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Reset: the reset is synchronous and active-low (rst_n low at a rising edge of clk). While rst_n is low, in_ready is 0. On reset, state goes to EMPTY, and every output register, including illegal_count, clears to 0. in_ready is 1 on the first cycle after release.
- Transfers: in-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready.
- Latency: an accepted instruction appears on out_valid on the next cycle.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: head register valid, in_ready=1.
  - TWO: head and skid valid, in_ready=0.
- Transitions:
  - EMPTY + in-transfer -> ONE.
  - ONE + in-transfer without out-transfer -> TWO; the new entry goes to skid.
  - ONE + in-transfer with out-transfer -> ONE; the new entry goes to head.
  - ONE + out-transfer only -> EMPTY.
  - TWO + out-transfer -> ONE; skid moves to head.
- in_ready is derived from the registered state only, never from out_ready.
- Head outputs stay stable while out_valid & !out_ready.
- Flush: flush_i high forces state EMPTY next cycle. It overrides any same-cycle in-transfer and out-transfer. An in-transfer in the flush cycle is dropped and not counted.
- Decode encoding:
  - ALU codes: add 0, sub 1, and 2, or 3, xor 4, sll 5, srl 6, sra 7, slt 8, sltu 9, lui 15, zero-extended to ALU_CTRL_W.
  - Branches use sub for beq/bne, slt for blt/bge, sltu for bltu/bgeu.
  - AUIPC: alu_src_a=1, alu_src_b=1, add.
  - JALR: alu_src_b=1, add.
  - addressing_control = funct3 for loads and stores, 0 otherwise.
- An instruction is illegal for any of:
  - unknown opcode;
  - R-type funct7 other than 0000000, or 0100000 only on add/sub and srl/sra;
  - slli/srli with funct7 other than 0000000, or srai with funct7 other than 0100000;
  - load funct3 of 011, 110 or 111;
  - store funct3 above 010;
  - branch funct3 of 010 or 011;
  - JALR funct3 other than 000.
- Illegal handling: illegal=1, and reg_write, mem_write, branch and jump are forced to 0. rd, rs1, rs2, out_pc and out_instr still pass through.
- illegal_count increments on each in-transfer of an illegal instruction and saturates at all ones.

Optional Feature:
- Macro RV32M_EN.
- Defined: opcode 0110011 with funct7 0000001 is legal and decodes to alu_control 16 + funct3 (mul 16 through remu 23), reg_write=1, result_src=00.
- Undefined: funct7 0000001 is illegal, and ALU_CTRL_W=4 is allowed.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams;
  - ALU code localparams;
  - imm_src, result_src and jump encodings;
  - a packed struct ctrl_t carrying the control bundle plus illegal, rd, rs1, rs2, pc and instr.
- Sub-module decode_comb: pure combinational instr -> ctrl_t. It is instantiated once, at the input side.
- The top level holds the skid FSM, the head and skid ctrl_t registers, and the counter.

Test Plan:
- Reset: hold rst_n low 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, illegal_count=0. First cycle after release -> in_ready=1.
- Decode: in_instr=0x40208033 (sub x0,x1,x2) accepted -> next cycle out_valid=1, alu_control=1, reg_write=1, rs1=1, rs2=2. Then 0x0000A083 (lw) -> result_src=01, alu_src_b=1, addressing_control=010.
- Backpressure: out_ready=0, send 2 instructions -> state TWO, in_ready=0, head stable. Raise out_ready -> both delivered in order on consecutive cycles, with no loss or duplication.
- Illegal: send 0x0000B003 (ld funct3 011) -> illegal=1, reg_write=0, count=1. Send 2^CNT_W+5 illegal instructions -> count stays 255 when CNT_W=8.
- Flush: state TWO, flush_i=1 with in_valid=1 on an illegal instruction -> next cycle out_valid=0, in_ready=1, count unchanged.
- RV32M: 0x02208033 (mul) -> with RV32M_EN defined, alu_control=16 and illegal=0. Without it, illegal=1.
